// File: rtl/cpu_bus_pkg.sv
// Shared types and default widths for the core memory bus arbiter.
// Holds the bus-owner and arbiter-state encodings used by bus_arbiter and arb_pick.
package cpu_bus_pkg;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_STB  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    localparam int BUS_WIDTH_DEF = 32;
    localparam int AD_LEN_DEF    = 32;

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational two-way owner picker for the bus arbiter.
// Macro BUS_ARB_RR_EN selects round-robin; otherwise fixed priority D over F.
import cpu_bus_pkg::*;

module arb_pick (
    input  logic   f_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output owner_t owner
);

    // Choose the next bus owner; with no request the previous owner is reported.
    always_comb begin
        owner = last_owner;
`ifdef BUS_ARB_RR_EN
        if (f_req && d_req) begin
            owner = (last_owner == OWN_D) ? OWN_F : OWN_D;
        end else if (d_req) begin
            owner = OWN_D;
        end else if (f_req) begin
            owner = OWN_F;
        end else begin
            owner = last_owner;
        end
`else
        if (d_req) begin
            owner = OWN_D;
        end else if (f_req) begin
            owner = OWN_F;
        end else begin
            owner = last_owner;
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory bus between instruction fetch (F) and load/store (D), one transaction at a time.
// Arbitration policy is set by BUS_ARB_RR_EN inside arb_pick (default: fixed priority, D over F).
import cpu_bus_pkg::*;

module bus_arbiter #(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int AD_LEN    = AD_LEN_DEF,
    parameter int MEM_LAT   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 f_req_i,
    input  logic [AD_LEN-1:0]    f_ad_i,
    output logic [BUS_WIDTH-1:0] f_data_o,
    output logic                 f_ack_o,
    input  logic                 d_req_i,
    input  logic                 d_we_i,
    input  logic [AD_LEN-1:0]    d_ad_i,
    input  logic [BUS_WIDTH-1:0] d_data_i,
    output logic [BUS_WIDTH-1:0] d_data_o,
    output logic                 d_ack_o,
    output logic [AD_LEN-1:0]    bus_ad_o,
    output logic [BUS_WIDTH-1:0] bus_data_o,
    output logic                 bus_we_o,
    output logic                 bus_stb_o,
    input  logic [BUS_WIDTH-1:0] bus_data_i,
    output logic                 busy_o
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_t       state_r;
    owner_t           owner_r;
    owner_t           last_owner_r;
    owner_t           pick_s;
    logic [CNT_W-1:0] cnt_r;
    logic             sample_s;

    arb_pick u_pick (
        .f_req      (f_req_i),
        .d_req      (d_req_i),
        .last_owner (last_owner_r),
        .owner      (pick_s)
    );

    // The edge leaving the last wait cycle is the one that samples read data.
    assign sample_s = ((state_r == ARB_STB) || (state_r == ARB_WAIT)) && (cnt_r == {CNT_W{1'b0}});

    // Arbiter FSM with all bus and port outputs registered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= ARB_IDLE;
            owner_r      <= OWN_D;
            last_owner_r <= OWN_D;
            cnt_r        <= {CNT_W{1'b0}};
            f_data_o     <= {BUS_WIDTH{1'b0}};
            f_ack_o      <= 1'b0;
            d_data_o     <= {BUS_WIDTH{1'b0}};
            d_ack_o      <= 1'b0;
            bus_ad_o     <= {AD_LEN{1'b0}};
            bus_data_o   <= {BUS_WIDTH{1'b0}};
            bus_we_o     <= 1'b0;
            bus_stb_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (f_req_i || d_req_i) begin
                        owner_r      <= pick_s;
                        last_owner_r <= pick_s;
                        if (pick_s == OWN_D) begin
                            bus_ad_o   <= d_ad_i;
                            bus_data_o <= d_data_i;
                            bus_we_o   <= d_we_i;
                        end else begin
                            bus_ad_o   <= f_ad_i;
                            bus_data_o <= {BUS_WIDTH{1'b0}};
                            bus_we_o   <= 1'b0;
                        end
                        bus_stb_o <= 1'b1;
                        busy_o    <= 1'b1;
                        cnt_r     <= CNT_INIT;
                        state_r   <= ARB_STB;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_STB: begin
                    bus_stb_o <= 1'b0;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ARB_DONE;
                    end else begin
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ARB_DONE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ARB_DONE: begin
                    f_ack_o <= 1'b0;
                    d_ack_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state_r <= ARB_IDLE;
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase

            if (sample_s) begin
                if (owner_r == OWN_D) begin
                    d_ack_o <= 1'b1;
                    if (!bus_we_o) begin
                        d_data_o <= bus_data_i;
                    end
                end else begin
                    f_ack_o  <= 1'b1;
                    f_data_o <= bus_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with MEM_LAT=2.
// Expectations follow the default fixed-priority build, or round-robin when BUS_ARB_RR_EN is defined.
module tb_bus_arbiter;

`ifdef BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        f_req_i;
    logic [31:0] f_ad_i;
    logic [31:0] f_data_o;
    logic        f_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_ad_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_ack_o;
    logic [31:0] bus_ad_o;
    logic [31:0] bus_data_o;
    logic        bus_we_o;
    logic        bus_stb_o;
    logic [31:0] bus_data_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.BUS_WIDTH(32), .AD_LEN(32), .MEM_LAT(2)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .f_req_i    (f_req_i),
        .f_ad_i     (f_ad_i),
        .f_data_o   (f_data_o),
        .f_ack_o    (f_ack_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_ad_i     (d_ad_i),
        .d_data_i   (d_data_i),
        .d_data_o   (d_data_o),
        .d_ack_o    (d_ack_o),
        .bus_ad_o   (bus_ad_o),
        .bus_data_o (bus_data_o),
        .bus_we_o   (bus_we_o),
        .bus_stb_o  (bus_stb_o),
        .bus_data_i (bus_data_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Grant edge through sample edge; records what the bus showed along the way.
    task automatic run_txn(input logic [31:0] rdata, output logic [31:0] ad_g,
                           output int stb_n, output logic fa, output logic da);
        stb_n = 0;
        step();
        ad_g  = bus_ad_o;
        stb_n += int'(bus_stb_o);
        step();
        stb_n += int'(bus_stb_o);
        bus_data_i = rdata;
        step();
        stb_n += int'(bus_stb_o);
        fa = f_ack_o;
        da = d_ack_o;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        f_req_i = 1'b0; f_ad_i = 32'h0; d_req_i = 1'b0; d_we_i = 1'b0;
        d_ad_i = 32'h0; d_data_i = 32'h0; bus_data_i = 32'h0;
        step();
        step();
        checks++; if ({f_ack_o, d_ack_o, bus_stb_o, bus_we_o, busy_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=%b", {f_ack_o, d_ack_o, bus_stb_o, bus_we_o, busy_o}, 5'b0); end
        checks++; if ({f_data_o, d_data_o, bus_ad_o, bus_data_o} !== 128'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {f_data_o, d_data_o, bus_ad_o, bus_data_o}); end
        reset_i = 1'b0;
        step();
        checks++; if (busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_fetch_read();
        f_req_i = 1'b1; f_ad_i = 32'h100;
        step();
        checks++; if ({bus_stb_o, busy_o, bus_we_o, f_ack_o} !== 4'b1100) begin
            errors++; $display("FAIL fetch_grant got=%b exp=1100", {bus_stb_o, busy_o, bus_we_o, f_ack_o}); end
        checks++; if (bus_ad_o !== 32'h100) begin
            errors++; $display("FAIL fetch_ad got=%h exp=%h", bus_ad_o, 32'h100); end
        step();
        checks++; if ({bus_stb_o, f_ack_o} !== 2'b00) begin
            errors++; $display("FAIL fetch_wait got=%b exp=00", {bus_stb_o, f_ack_o}); end
        bus_data_i = 32'hDEADBEEF;
        step();
        checks++; if ({f_ack_o, d_ack_o} !== 2'b10) begin
            errors++; $display("FAIL fetch_ack got=%b exp=10", {f_ack_o, d_ack_o}); end
        checks++; if (f_data_o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_data got=%h exp=%h", f_data_o, 32'hDEADBEEF); end
        f_req_i = 1'b0; bus_data_i = 32'h0;
        step();
        checks++; if ({f_ack_o, busy_o, bus_stb_o} !== 3'b000) begin
            errors++; $display("FAIL fetch_end got=%b exp=000", {f_ack_o, busy_o, bus_stb_o}); end
        checks++; if (f_data_o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_hold got=%h exp=%h", f_data_o, 32'hDEADBEEF); end
    endtask

    task automatic test_lsu_read();
        logic [31:0] ad_g; int stb_n; logic fa, da;
        d_req_i = 1'b1; d_we_i = 1'b0; d_ad_i = 32'h3000;
        run_txn(32'hCAFEF00D, ad_g, stb_n, fa, da);
        checks++; if ({fa, da, ad_g} !== {2'b01, 32'h3000}) begin
            errors++; $display("FAIL lsu_read_ack got=%b_%h exp=01_%h", {fa, da}, ad_g, 32'h3000); end
        checks++; if (d_data_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL lsu_read_data got=%h exp=%h", d_data_o, 32'hCAFEF00D); end
        d_req_i = 1'b0;
        step();
    endtask

    task automatic test_lsu_write();
        d_req_i = 1'b1; d_we_i = 1'b1; d_ad_i = 32'h2000; d_data_i = 32'h12345678;
        step();
        checks++; if ({bus_stb_o, bus_we_o, bus_ad_o, bus_data_o} !== {2'b11, 32'h2000, 32'h12345678}) begin
            errors++; $display("FAIL write_grant got=%b_%h_%h exp=11_2000_12345678", {bus_stb_o, bus_we_o}, bus_ad_o, bus_data_o); end
        d_data_i = 32'h0; d_we_i = 1'b0; d_ad_i = 32'h0;
        step();
        checks++; if ({bus_stb_o, bus_we_o, bus_data_o} !== {2'b01, 32'h12345678}) begin
            errors++; $display("FAIL write_wait got=%b_%h exp=01_12345678", {bus_stb_o, bus_we_o}, bus_data_o); end
        bus_data_i = 32'hFFFFFFFF;
        step();
        checks++; if ({d_ack_o, f_ack_o, bus_we_o} !== 3'b101) begin
            errors++; $display("FAIL write_ack got=%b exp=101", {d_ack_o, f_ack_o, bus_we_o}); end
        checks++; if (d_data_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL write_d_data got=%h exp=%h", d_data_o, 32'hCAFEF00D); end
        d_req_i = 1'b0; bus_data_i = 32'h0;
        step();
        checks++; if ({d_ack_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL write_end got=%b exp=00", {d_ack_o, busy_o}); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] ad_g; int stb_n; logic fa, da; logic exp_f;
        f_req_i = 1'b1; f_ad_i = 32'h300;
        d_req_i = 1'b1; d_ad_i = 32'h400; d_we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_f = RR && ((i % 2) == 0);
            run_txn(32'h1000 + 32'(i), ad_g, stb_n, fa, da);
            checks++; if ({fa, da} !== {exp_f, ~exp_f}) begin
                errors++; $display("FAIL both_owner[%0d] got=%b exp=%b", i, {fa, da}, {exp_f, ~exp_f}); end
            checks++; if (ad_g !== (exp_f ? 32'h300 : 32'h400)) begin
                errors++; $display("FAIL both_ad[%0d] got=%h exp=%h", i, ad_g, exp_f ? 32'h300 : 32'h400); end
            checks++; if ((exp_f ? f_data_o : d_data_o) !== 32'h1000 + 32'(i)) begin
                errors++; $display("FAIL both_data[%0d] got=%h exp=%h", i, exp_f ? f_data_o : d_data_o, 32'h1000 + 32'(i)); end
            checks++; if (stb_n !== 1) begin
                errors++; $display("FAIL both_stb[%0d] got=%0d exp=1", i, stb_n); end
            if (i == 3) d_req_i = 1'b0;
            step();
            checks++; if ({f_ack_o, d_ack_o, busy_o} !== 3'b000) begin
                errors++; $display("FAIL both_gap[%0d] got=%b exp=000", i, {f_ack_o, d_ack_o, busy_o}); end
        end
        run_txn(32'h2222, ad_g, stb_n, fa, da);
        checks++; if ({fa, da, ad_g, f_data_o} !== {2'b10, 32'h300, 32'h2222}) begin
            errors++; $display("FAIL f_after_d got=%b_%h_%h exp=10_300_2222", {fa, da}, ad_g, f_data_o); end
        f_req_i = 1'b0;
        step();
    endtask

    task automatic test_addr_change();
        f_req_i = 1'b1; f_ad_i = 32'h100;
        step();
        checks++; if (bus_ad_o !== 32'h100) begin
            errors++; $display("FAIL chg_grant_ad got=%h exp=%h", bus_ad_o, 32'h100); end
        step();
        f_ad_i = 32'h200;
        bus_data_i = 32'h0BADF00D;
        step();
        checks++; if ({f_ack_o, bus_stb_o, bus_ad_o} !== {2'b10, 32'h100}) begin
            errors++; $display("FAIL chg_ack_ad got=%b_%h exp=10_100", {f_ack_o, bus_stb_o}, bus_ad_o); end
        f_req_i = 1'b0;
        step();
        step();
        checks++; if ({bus_stb_o, busy_o, bus_ad_o} !== {2'b00, 32'h100}) begin
            errors++; $display("FAIL chg_no_restb got=%b_%h exp=00_100", {bus_stb_o, busy_o}, bus_ad_o); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] exp_ad;
        f_req_i = 1'b1; f_ad_i = 32'h100;
        step();
        step();
        checks++; if ({busy_o, bus_stb_o} !== 2'b10) begin
            errors++; $display("FAIL rst_pre_wait got=%b exp=10", {busy_o, bus_stb_o}); end
        #2 reset_i = 1'b1;
        #1;
        checks++; if ({f_ack_o, d_ack_o, bus_stb_o, bus_we_o, busy_o} !== 5'b0) begin
            errors++; $display("FAIL rst_async_ctrl got=%b exp=00000", {f_ack_o, d_ack_o, bus_stb_o, bus_we_o, busy_o}); end
        checks++; if ({f_data_o, d_data_o, bus_ad_o, bus_data_o} !== 128'h0) begin
            errors++; $display("FAIL rst_async_data got=%h exp=0", {f_data_o, d_data_o, bus_ad_o, bus_data_o}); end
        d_req_i = 1'b1; d_we_i = 1'b0; d_ad_i = 32'h500;
        #2 reset_i = 1'b0;
        exp_ad = RR ? 32'h100 : 32'h500;
        step();
        checks++; if ({bus_stb_o, f_ack_o, d_ack_o, bus_ad_o} !== {3'b100, exp_ad}) begin
            errors++; $display("FAIL rst_regrant got=%b_%h exp=100_%h", {bus_stb_o, f_ack_o, d_ack_o}, bus_ad_o, exp_ad); end
        step();
        bus_data_i = 32'h55AA55AA;
        step();
        checks++; if ({f_ack_o, d_ack_o} !== {RR, ~RR}) begin
            errors++; $display("FAIL rst_regrant_ack got=%b exp=%b", {f_ack_o, d_ack_o}, {RR, ~RR}); end
        f_req_i = 1'b0; d_req_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_lsu_read();
        test_lsu_write();
        test_simultaneous();
        test_addr_change();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
